// File: rtl/avalon_cipher_csr.sv
// rtl/avalon_cipher_csr.sv - Avalon-MM CSR bank that loads, launches and collects a block-cipher core
module avalon_cipher_csr #(
    parameter int KEY_WORDS  = 4,
    parameter int MSG_WORDS  = 4,
    parameter int ADDR_W     = 4,
    parameter int TIMEOUT    = 1024,
    parameter int EXPORT_SEL = 0
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   AVL_READ,
    input  logic                   AVL_WRITE,
    input  logic                   AVL_CS,
    input  logic [3:0]             AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]      AVL_ADDR,
    input  logic [31:0]            AVL_WRITEDATA,
    output logic [31:0]            AVL_READDATA,
    output logic                   IRQ,
    output logic [31:0]            EXPORT_DATA,
    output logic                   CORE_START,
    output logic [32*KEY_WORDS-1:0] CORE_KEY,
    output logic [32*MSG_WORDS-1:0] CORE_MSG_IN,
    input  logic                   CORE_DONE,
    input  logic [32*MSG_WORDS-1:0] CORE_MSG_OUT
);
    localparam int MSG_IN_BASE  = KEY_WORDS;
    localparam int MSG_OUT_BASE = KEY_WORDS + MSG_WORDS;
    localparam int CTRL_ADDR    = KEY_WORDS + 2 * MSG_WORDS;
    localparam int STATUS_ADDR  = CTRL_ADDR + 1;
    localparam int CNT_W        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE} state_t;

    state_t           state, state_nxt;
    logic [31:0]      key_reg     [KEY_WORDS];
    logic [31:0]      msg_in_reg  [MSG_WORDS];
    logic [31:0]      msg_out_reg [MSG_WORDS];
    logic [31:0]      reg_view    [2**ADDR_W];
    logic [31:0]      rdata_reg;
    logic [CNT_W-1:0] tmo_cnt;
    logic             irq_en, done_flag, err_flag, tmo_flag, irq_reg;
    logic             busy, wr_en, data_wr, ctrl_wr, start_req, clr_req;
    logic             launch, clr_any, timeout_hit;
    int               wr_idx;

    function automatic logic [31:0] merge_be(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

    assign wr_idx    = int'(AVL_ADDR);
    assign wr_en     = AVL_CS && AVL_WRITE;
    assign busy      = (state != S_IDLE);
    assign data_wr   = wr_en && (wr_idx < MSG_OUT_BASE);
    assign ctrl_wr   = wr_en && (wr_idx == CTRL_ADDR) && AVL_BYTE_EN[0];
    assign start_req = ctrl_wr && AVL_WRITEDATA[0];
    assign clr_req   = ctrl_wr && AVL_WRITEDATA[2];
    assign launch    = (state == S_IDLE) && start_req;
    assign clr_any   = clr_req || launch;
    // A CORE_DONE in the last allowed WAIT cycle still wins over the abort.
    assign timeout_hit = (TIMEOUT != 0) && (state == S_WAIT) && !CORE_DONE &&
                         (int'(tmo_cnt) + 1 >= TIMEOUT);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_req) state_nxt = S_LAUNCH;
            S_LAUNCH:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (CORE_DONE)
                    state_nxt = S_CAPTURE;
                else if (timeout_hit)
                    state_nxt = S_IDLE;
            end
            S_CAPTURE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < KEY_WORDS; i++) key_reg[i] <= '0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                msg_in_reg[i]  <= '0;
                msg_out_reg[i] <= '0;
            end
            irq_en    <= 1'b0;
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
            tmo_flag  <= 1'b0;
            irq_reg   <= 1'b0;
            rdata_reg <= '0;
            tmo_cnt   <= '0;
        end else begin
            for (int i = 0; i < KEY_WORDS; i++)
                if (data_wr && !busy && wr_idx == i)
                    key_reg[i] <= merge_be(key_reg[i], AVL_WRITEDATA, AVL_BYTE_EN);
            for (int i = 0; i < MSG_WORDS; i++)
                if (data_wr && !busy && wr_idx == MSG_IN_BASE + i)
                    msg_in_reg[i] <= merge_be(msg_in_reg[i], AVL_WRITEDATA, AVL_BYTE_EN);
            // Result is only guaranteed while CORE_DONE is high, so grab it then.
            if (state == S_WAIT && CORE_DONE)
                for (int i = 0; i < MSG_WORDS; i++)
                    msg_out_reg[i] <= CORE_MSG_OUT[32*(MSG_WORDS-i)-1 -: 32];
            if (ctrl_wr)
                irq_en <= AVL_WRITEDATA[1];
            done_flag <= (state == S_CAPTURE) || (done_flag && !clr_any);
            err_flag  <= (busy && (data_wr || start_req)) || timeout_hit ||
                         (err_flag && !clr_any);
            tmo_flag  <= timeout_hit || (tmo_flag && !clr_any);
            irq_reg   <= done_flag && irq_en;
            if (AVL_CS && AVL_READ)
                rdata_reg <= reg_view[AVL_ADDR];
            if (state == S_LAUNCH)
                tmo_cnt <= '0;
            else if (state == S_WAIT && tmo_cnt != CNT_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < 2**ADDR_W; g++) begin : g_view
        if (g < MSG_IN_BASE) begin : g_key
            assign reg_view[g] = key_reg[g];
        end else if (g < MSG_OUT_BASE) begin : g_min
            assign reg_view[g] = msg_in_reg[g-MSG_IN_BASE];
        end else if (g < CTRL_ADDR) begin : g_mout
            assign reg_view[g] = msg_out_reg[g-MSG_OUT_BASE];
        end else if (g == CTRL_ADDR) begin : g_ctrl
            assign reg_view[g] = {30'd0, irq_en, 1'b0};
        end else if (g == STATUS_ADDR) begin : g_stat
            assign reg_view[g] = {28'd0, tmo_flag, err_flag, done_flag, busy};
        end else begin : g_none
            assign reg_view[g] = '0;
        end
    end

    for (genvar g = 0; g < KEY_WORDS; g++) begin : g_core_key
        assign CORE_KEY[32*(KEY_WORDS-g)-1 -: 32] = key_reg[g];
    end
    for (genvar g = 0; g < MSG_WORDS; g++) begin : g_core_msg
        assign CORE_MSG_IN[32*(MSG_WORDS-g)-1 -: 32] = msg_in_reg[g];
    end

    assign CORE_START   = (state == S_LAUNCH);
    assign AVL_READDATA = rdata_reg;
    assign IRQ          = irq_reg;
    assign EXPORT_DATA  = reg_view[ADDR_W'(EXPORT_SEL)];
endmodule

// File: tb/tb_avalon_cipher_csr.sv
// tb/tb_avalon_cipher_csr.sv - scoreboard bench for avalon_cipher_csr with a transaction-level model
module tb_avalon_cipher_csr;
    localparam int K = 4, M = 4, AW = 4, TMO = 16;
    localparam int CTRL_A = K + 2 * M, STAT_A = CTRL_A + 1;

    logic            CLK = 1'b0, RESET_N = 1'b0;
    logic            AVL_READ = 1'b0, AVL_WRITE = 1'b0, AVL_CS = 1'b0;
    logic [3:0]      AVL_BYTE_EN = '0;
    logic [AW-1:0]   AVL_ADDR = '0;
    logic [31:0]     AVL_WRITEDATA = '0;
    logic [31:0]     AVL_READDATA, EXPORT_DATA;
    logic            IRQ, CORE_START;
    logic [32*K-1:0] CORE_KEY;
    logic [32*M-1:0] CORE_MSG_IN;
    logic            CORE_DONE = 1'b0;
    logic [32*M-1:0] CORE_MSG_OUT = '0;

    always #5 CLK = ~CLK;

    avalon_cipher_csr #(.KEY_WORDS(K), .MSG_WORDS(M), .ADDR_W(AW), .TIMEOUT(TMO), .EXPORT_SEL(0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR), .AVL_WRITEDATA(AVL_WRITEDATA),
        .AVL_READDATA(AVL_READDATA), .IRQ(IRQ), .EXPORT_DATA(EXPORT_DATA), .CORE_START(CORE_START),
        .CORE_KEY(CORE_KEY), .CORE_MSG_IN(CORE_MSG_IN), .CORE_DONE(CORE_DONE), .CORE_MSG_OUT(CORE_MSG_OUT));

    int total = 0, bad = 0, cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: register contents plus the edge at which the running job finishes.
    logic [31:0]     m_key [K], m_in [M], m_out [M];
    logic            m_irq_en, m_done, m_err, m_tmo, m_busy, m_fin_tmo;
    int              m_start, m_fin, m_lat;
    logic [32*M-1:0] m_res;
    int              core_lat = 1;
    logic [32*M-1:0] core_res = '0;
    int              exp_starts = 0, seen_starts = 0, seen_start_cyc = -1;

    task automatic model_reset();
        for (int i = 0; i < K; i++) m_key[i] = '0;
        for (int i = 0; i < M; i++) begin m_in[i] = '0; m_out[i] = '0; end
        {m_irq_en, m_done, m_err, m_tmo, m_busy, m_fin_tmo} = '0;
        m_start = 0; m_fin = 0;
    endtask

    task automatic settle(input int e);
        if (m_busy && e >= m_fin) begin
            m_busy = 1'b0;
            if (m_fin_tmo) begin
                m_err = 1'b1; m_tmo = 1'b1;
            end else begin
                m_done = 1'b1;
                for (int i = 0; i < M; i++) m_out[i] = m_res[32*(M-i)-1 -: 32];
            end
        end
    endtask

    function automatic logic [31:0] model_word(input int a);
        if (a < K)            return m_key[a];
        if (a < K + M)        return m_in[a-K];
        if (a < K + 2 * M)    return m_out[a-K-M];
        if (a == CTRL_A)      return {30'd0, m_irq_en, 1'b0};
        if (a == STAT_A)      return {28'd0, m_tmo, m_err, m_done, m_busy};
        return 32'd0;
    endfunction

    function automatic logic [31:0] be_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (o & ~mask) | (d & mask);
    endfunction

    // Scoreboard: reads push the model's answer, the monitor pops it one cycle later.
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_v = 1'b0;
    always @(posedge CLK or negedge RESET_N)
        if (!RESET_N) rd_v <= 1'b0;
        else          rd_v <= AVL_CS && AVL_READ;

    always @(negedge CLK) begin
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %0h with no read pending", AVL_READDATA);
            end else begin
                logic [31:0] ev;
                string nm;
                ev = exp_q.pop_front();
                nm = name_q.pop_front();
                check(nm, AVL_READDATA, ev);
            end
        end
    end

    // Core model: responds m_lat cycles after CORE_START (0 = never), result held afterwards.
    int core_cnt = 0;
    always @(negedge CLK) begin
        if (CORE_DONE) CORE_DONE = 1'b0;
        if (CORE_START === 1'b1) begin
            seen_starts++;
            seen_start_cyc = cyc;
            core_cnt = m_lat;
            CORE_MSG_OUT = {$urandom, $urandom, $urandom, $urandom};
        end else if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                CORE_DONE = 1'b1;
                CORE_MSG_OUT = m_res;
            end
        end
    end

    task automatic drive(input logic rd, input logic wr, input int a, input logic [31:0] d, input logic [3:0] be);
        AVL_CS = rd | wr; AVL_READ = rd; AVL_WRITE = wr;
        AVL_ADDR = AW'(a); AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    endtask

    task automatic bus_idle();
        @(negedge CLK);
        drive(1'b0, 1'b0, 0, 32'd0, 4'd0);
    endtask

    task automatic wait_until_edge(input int e);
        while (cyc + 2 < e) bus_idle();
    endtask

    task automatic bus_read(input int a, input string nm);
        @(negedge CLK);
        settle(cyc);
        exp_q.push_back(model_word(a));
        name_q.push_back(nm);
        drive(1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] be);
        int e;
        logic busy_now, start, clr, dwr;
        @(negedge CLK);
        e = cyc + 1;
        settle(e - 1);
        busy_now = m_busy;
        {start, clr, dwr} = '0;
        drive(1'b0, 1'b1, a, d, be);
        if (a < K + M) begin
            dwr = 1'b1;
            if (!busy_now) begin
                if (a < K) m_key[a] = be_merge(m_key[a], d, be);
                else       m_in[a-K] = be_merge(m_in[a-K], d, be);
            end
        end else if (a == CTRL_A && be[0]) begin
            m_irq_en = d[1]; start = d[0]; clr = d[2];
        end
        if (clr || (start && !busy_now)) {m_done, m_err, m_tmo} = '0;
        if (start && !busy_now) begin
            m_busy = 1'b1; m_start = e; m_res = core_res; m_lat = core_lat;
            exp_starts++;
            if (core_lat == 0 || core_lat > TMO) begin m_fin = e + TMO + 1; m_fin_tmo = 1'b1; end
            else begin m_fin = e + core_lat + 2; m_fin_tmo = 1'b0; end
        end
        settle(e);
        if (busy_now && (start || dwr)) m_err = 1'b1;
    endtask

    task automatic check_irq(input string nm);
        bus_idle(); bus_idle();
        settle(cyc - 1);
        check(nm, IRQ, m_done & m_irq_en);
    endtask

    task automatic check_core_ports(input string nm);
        logic [32*K-1:0] ek;
        logic [32*M-1:0] em;
        for (int i = 0; i < K; i++) ek[32*(K-i)-1 -: 32] = m_key[i];
        for (int i = 0; i < M; i++) em[32*(M-i)-1 -: 32] = m_in[i];
        check({nm, "_key"}, CORE_KEY, ek);
        check({nm, "_msg_in"}, CORE_MSG_IN, em);
        check({nm, "_export"}, EXPORT_DATA, m_key[0]);
    endtask

    initial begin
        int es;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_core_start", CORE_START, 1'b0);
        check("rst_readdata", AVL_READDATA, 32'd0);
        check("rst_irq", IRQ, 1'b0);
        check("rst_export", EXPORT_DATA, 32'd0);
        RESET_N = 1'b1;

        for (int a = 0; a < 16; a++) bus_read(a, "rd_after_reset");

        bus_write(0, 32'hDEADBEEF, 4'b0101);
        bus_read(0, "key0_byte_en");
        repeat (3) bus_idle();
        check("rd_hold", AVL_READDATA, 32'h00AD00EF);
        check("core_key_ms_word", CORE_KEY[32*K-1 -: 32], 32'h00AD00EF);

        for (int i = 0; i < K + M; i++) bus_write(i, $urandom, 4'hF);
        bus_idle();
        check_core_ports("loaded");
        core_res = 128'h00112233445566778899AABBCCDDEEFF;
        core_lat = 10;
        bus_write(CTRL_A, 32'h3, 4'h1);
        es = m_start;
        bus_read(STAT_A, "stat_busy");
        wait_until_edge(es + 12);
        bus_read(STAT_A, "stat_before_done");
        bus_read(STAT_A, "stat_done");
        for (int i = 0; i < M; i++) bus_read(K + M + i, "msg_out_result");
        check("start_cycle", seen_start_cyc, es);
        check("start_count_op1", seen_starts, exp_starts);
        check_irq("irq_done");

        core_lat = 12;
        core_res = {$urandom, $urandom, $urandom, $urandom};
        bus_write(CTRL_A, 32'h3, 4'h1);
        es = m_start;
        wait_until_edge(es + 5);
        bus_write(K, $urandom, 4'hF);
        bus_write(CTRL_A, 32'h3, 4'h1);
        bus_read(K, "msg_in0_locked");
        bus_read(STAT_A, "stat_busy_err");
        check_core_ports("locked");
        wait_until_edge(es + 20);
        bus_read(STAT_A, "stat_done_err");
        check("start_count_op2", seen_starts, exp_starts);

        core_lat = 0;
        bus_write(CTRL_A, 32'h3, 4'h1);
        es = m_start;
        wait_until_edge(es + TMO + 1);
        bus_read(STAT_A, "stat_last_wait");
        bus_read(STAT_A, "stat_timeout");
        for (int i = 0; i < M; i++) bus_read(K + M + i, "msg_out_kept");
        core_lat = 5;
        core_res = {$urandom, $urandom, $urandom, $urandom};
        bus_write(CTRL_A, 32'h3, 4'h1);
        es = m_start;
        wait_until_edge(es + 7);
        bus_write(CTRL_A, 32'h6, 4'h1);
        bus_read(STAT_A, "stat_clr_vs_done");
        check_irq("irq_after_retry");
        bus_write(CTRL_A, 32'h6, 4'h1);
        check_irq("irq_after_clr");
        bus_read(STAT_A, "stat_cleared");

        core_lat = 12;
        core_res = {$urandom, $urandom, $urandom, $urandom};
        bus_write(CTRL_A, 32'h3, 4'h1);
        es = m_start;
        wait_until_edge(es + 5);
        bus_idle();
        #2 RESET_N = 1'b0;
        model_reset();
        @(negedge CLK);
        check("mid_rst_core_start", CORE_START, 1'b0);
        check("mid_rst_readdata", AVL_READDATA, 32'd0);
        check("mid_rst_irq", IRQ, 1'b0);
        RESET_N = 1'b1;
        repeat (14) bus_idle();
        bus_read(STAT_A, "stat_late_done");
        for (int i = 0; i < M; i++) bus_read(K + M + i, "msg_out_late_done");
        check("start_count_reset", seen_starts, exp_starts);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 5))
                0: bus_write($urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)));
                1, 2: bus_read($urandom_range(0, 15), "rd_random");
                3: begin
                    core_lat = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 14);
                    core_res = {$urandom, $urandom, $urandom, $urandom};
                    bus_write(CTRL_A, {29'd0, 1'($urandom_range(0, 1)), 2'b11}, 4'h1);
                end
                4: bus_idle();
                default: check_irq("irq_random");
            endcase
        end
        repeat (20) bus_idle();
        for (int a = 0; a < 16; a++) bus_read(a, "rd_final");
        repeat (3) bus_idle();
        check_core_ports("final");
        check("start_count_final", seen_starts, exp_starts);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
